// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: synchronizer, press/release debounce FSM, long-press
// detection and a wrapping press counter. All outputs are registered.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       btn_level_n,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    // Counter value just before it advances to LONG_CYCLES-1
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t             state_r;
    logic               sync1_r;
    logic               sync_r;
    logic [DB_W-1:0]    db_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic               long_fire_s;

    assign long_fire_s = (hold_cnt_r == HOLD_FIRE);

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync_r  <= 1'b1;
        end else begin
            sync1_r <= btn_n;
            sync_r  <= sync1_r;
        end
    end

    // Debounce FSM with hold counter and registered pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            db_cnt_r      <= DB_ZERO;
            hold_cnt_r    <= HOLD_ZERO;
            btn_level_n   <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            // Hold time keeps accumulating through release bounces
            if ((state_r == HELD || state_r == RELEASE_DB) && hold_cnt_r != HOLD_MAX) begin
                hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (!sync_r) begin
                        state_r  <= PRESS_DB;
                        db_cnt_r <= DB_ZERO;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                PRESS_DB: begin
                    if (sync_r) begin
                        state_r <= IDLE;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r     <= HELD;
                        btn_level_n <= 1'b0;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt_r  <= HOLD_ZERO;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                HELD: begin
                    long_press <= long_fire_s;
                    if (sync_r) begin
                        state_r  <= RELEASE_DB;
                        db_cnt_r <= DB_ZERO;
                    end else begin
                        state_r  <= HELD;
                    end
                end
                RELEASE_DB: begin
                    if (!sync_r) begin
                        state_r    <= HELD;
                        long_press <= long_fire_s;
                    end else if (db_cnt_r == DB_LAST) begin
                        // Release wins; a long press that was never reached is dropped
                        state_r       <= IDLE;
                        btn_level_n   <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt_r   <= db_cnt_r + DB_ONE;
                        long_press <= long_fire_s;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    db_cnt_r <= DB_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
// stimulus queues expected pulse events, a monitor pops and checks them.
module tb_btn_conditioner;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int PRESS_LAT = DB + 3;     // drive at negedge k -> pulse seen at cyc k+7
    localparam int LONG_LAT  = DB + 2 + LONG;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       btn_level_n;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    typedef struct {
        int kind;   // 0 press, 1 release, 2 long
        int cyc;
        int cnt;
        int lvl;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_press = 0;
    int  n_rel = 0;

    btn_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .btn_level_n(btn_level_n),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_press(long_press), .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int cnt, input int lvl);
        ev_t e;
        e.kind = kind; e.cyc = at; e.cnt = cnt; e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && (press_pulse || release_pulse || long_press)) begin
            ev_t e;
            int  kind;
            chk("pulse_exclusive", int'(press_pulse) + int'(release_pulse) + int'(long_press), 1);
            kind = press_pulse ? 0 : (release_pulse ? 1 : 2);
            if (press_pulse) n_press <= n_press + 1;
            if (release_pulse) n_rel <= n_rel + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                chk("event_press_count", int'(press_count), e.cnt);
                chk("event_level", int'(btn_level_n), e.lvl);
            end
        end
    end

    task automatic press_release(input int hold, input int cnt, input bit exp_long, input int gap);
        int t;
        t = cyc;
        btn_n = 1'b0;
        push(0, t + PRESS_LAT, cnt, 0);
        if (exp_long) push(2, t + LONG_LAT, cnt, 0);
        repeat (hold) @(negedge clk);
        t = cyc;
        btn_n = 1'b1;
        push(1, t + PRESS_LAT, cnt, 1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_level"}, int'(btn_level_n), 1);
        chk({tag, "_pulses"}, int'({press_pulse, release_pulse, long_press}), 0);
        chk({tag, "_count"}, int'(press_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Watchdog: any hang is reported and ends the run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int p0;
        int r0;
        rst   = 1'b1;
        btn_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        do_reset();
        repeat (3) @(negedge clk);

        // Clean press held 30 cycles: press, one long press, release
        press_release(30, 1, 1'b1, 15);
        chk("clean_count", int'(press_count), 1);

        // Press bounce: low for 3 cycles only
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_level", int'(btn_level_n), 1);
        chk("bounce_count", int'(press_count), 1);

        // Release bounce: high 2, low 2, then high for good
        t = cyc;
        btn_n = 1'b0;
        push(0, t + PRESS_LAT, 2, 0);
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
        repeat (2) @(negedge clk);
        btn_n = 1'b0;
        repeat (2) @(negedge clk);
        t = cyc;
        btn_n = 1'b1;
        push(1, t + PRESS_LAT, 2, 1);
        repeat (15) @(negedge clk);
        chk("relbounce_count", int'(press_count), 2);

        // Reset mid-hold, button kept low across reset
        t = cyc;
        btn_n = 1'b0;
        push(0, t + PRESS_LAT, 3, 0);
        repeat (12) @(negedge clk);
        chk("midhold_level", int'(btn_level_n), 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midhold_rst");
        @(negedge clk);
        @(negedge clk);
        t = cyc;
        rst = 1'b0;
        push(0, t + PRESS_LAT, 1, 0);
        push(2, t + LONG_LAT, 1, 0);
        repeat (30) @(negedge clk);
        t = cyc;
        btn_n = 1'b1;
        push(1, t + PRESS_LAT, 1, 1);
        repeat (15) @(negedge clk);
        chk("post_rst_count", int'(press_count), 1);

        // Wrap: 256 press/release pairs from a fresh reset
        do_reset();
        @(negedge clk);
        chk("wrap_start_count", int'(press_count), 0);
        p0 = n_press;
        r0 = n_rel;
        for (int i = 0; i < 256; i++) begin
            press_release(10, (i + 1) % 256, 1'b0, 12);
        end
        chk("wrap_count", int'(press_count), 0);
        chk("wrap_press_pulses", n_press - p0, 256);
        chk("wrap_release_pulses", n_rel - r0, 256);

        repeat (10) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-input time in clk cycles before a level change is accepted (20 ms at 50 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 250000000, meaning the held time in clk cycles after debounce before long_press fires (5 s at 50 MHz); legal range > DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port btn_n, input, 1 bit: raw pushbutton, active-low (0 = pressed), asynchronous to clk, may bounce.
REQ-006 The block SHALL have port btn_level_n, output, 1 bit: debounced level, active-low, registered; feeds the test-mode button stage directly.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle pulse per accepted press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle pulse per accepted release.
REQ-009 The block SHALL have port long_press, output, 1 bit: one-cycle pulse when a press has been held LONG_CYCLES.
REQ-010 The block SHALL have port press_count, output, 8 bits: number of accepted presses since reset, modulo 256.

Function
REQ-011 btn_n SHALL pass through a two-flop synchronizer (both flops reset to 1); only the second flop output (sync) is used by the block logic.
REQ-012 The FSM SHALL have states IDLE, PRESS_DB, HELD and RELEASE_DB, one debounce counter (db_cnt) and one hold counter (hold_cnt).
REQ-013 In IDLE with sync=0, the FSM SHALL move to PRESS_DB and clear db_cnt; with sync=1 it stays in IDLE.
REQ-014 In PRESS_DB with sync=1, the FSM SHALL return to IDLE with no output change (bounce rejected).
REQ-015 In PRESS_DB with sync=0 and db_cnt < DEBOUNCE_CYCLES-1, the FSM SHALL increment db_cnt.
REQ-016 In PRESS_DB with sync=0 and db_cnt = DEBOUNCE_CYCLES-1, the FSM SHALL move to HELD, set btn_level_n=0, pulse press_pulse, increment press_count (255 wraps to 0) and clear hold_cnt.
REQ-017 In HELD, hold_cnt SHALL increment each cycle, saturating at LONG_CYCLES.
REQ-018 In HELD, long_press SHALL pulse on the cycle hold_cnt advances to LONG_CYCLES-1, at most once per accepted press.
REQ-019 In HELD with sync=1, the FSM SHALL move to RELEASE_DB and clear db_cnt; hold_cnt keeps counting.
REQ-020 In RELEASE_DB with sync=0, the FSM SHALL return to HELD with no press_pulse, no press_count change and hold_cnt not cleared (release bounce).
REQ-021 In RELEASE_DB with sync=1 and db_cnt = DEBOUNCE_CYCLES-1, the FSM SHALL move to IDLE, set btn_level_n=1 and pulse release_pulse.
REQ-022 Latency: with btn_n held stably low, press_pulse and the btn_level_n fall SHALL appear after clk edge DEBOUNCE_CYCLES+2, counted from edge 0 (the first edge on which the synchronizer captures 0).
REQ-023 The release path SHALL have the same latency as the press path, per REQ-022.
REQ-024 press_pulse, release_pulse and long_press SHALL be registered and mutually exclusive in any cycle.
REQ-025 Counter widths SHALL be $clog2 of their maximum value plus 1 so that no overflow occurs at the maximum parameter values.

Reset
REQ-026 While rst=1, the block SHALL force state IDLE, db_cnt=0, hold_cnt=0, both synchronizer flops=1, btn_level_n=1, press_pulse=0, release_pulse=0, long_press=0 and press_count=0.
REQ-027 Reset asserted mid-press SHALL abort the press with no release_pulse; after rst falls with btn_n still low, a new full debounce SHALL be required before press_pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-028 Clean press: btn_n 1->0 held 30 cycles -> press_pulse high exactly 1 cycle after edge 6; btn_level_n=0 from then; press_count=1; long_press 1 pulse; no second long_press.
REQ-029 Press bounce: btn_n low for 3 cycles then high -> no pulses; btn_level_n stays 1; press_count stays 0.
REQ-030 Release bounce: after an accepted press, btn_n high for 2 cycles, low for 2, then high 10 -> exactly one release_pulse, after the final stable-high debounce; no extra press_pulse.
REQ-031 Wrap: 256 clean press/release pairs -> press_count returns to 0; 256 press_pulse and 256 release_pulse observed.
REQ-032 Reset mid-hold: rst pulsed while HELD with btn_n low -> all outputs at reset values immediately; press_pulse recurs 6 edges after rst deasserts; press_count=1.
